// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the microprocessor front end.
//   INSTR_W / PC_W      : instruction and program-address widths
//   *_LO / *_HI         : instruction field bit positions
//   OP_*                : opcode encodings
//   fetch_entry_t       : one fetched {pc, instr} pair as held in the fetch queue
//   instr_opcode()      : helper that extracts the opcode field
package cpu_pkg;

  localparam int INSTR_W = 12;
  localparam int PC_W    = 3;

  // Instruction fields, LSB first: opcode, loc1, loc2, wloc.
  localparam int OPC_LO  = 0;
  localparam int OPC_HI  = 2;
  localparam int LOC1_LO = 3;
  localparam int LOC1_HI = 5;
  localparam int LOC2_LO = 6;
  localparam int LOC2_HI = 8;
  localparam int WLOC_LO = 9;
  localparam int WLOC_HI = 11;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_XOR = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_JMP = 3'd3;
  localparam logic [2:0] OP_NOP = 3'd4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [2:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- bundles the ROM port, redirect input and decode handshake
// of the fetch stage.
//   imem_addr/imem_data          : program ROM read port (combinational ROM)
//   redirect_valid/redirect_pc   : taken jump from the branch logic
//   out_valid/out_ready          : head-of-queue handshake towards decode
//   out_instr/out_pc             : head instruction and the address it came from
//   count                        : queue occupancy, debug/verification only
// master: the fetch stage.  slave: its environment (ROM, branch unit, decode).
interface fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [CNT_W-1:0]   count;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, count,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, count,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fq_storage.sv
// fq_storage -- DEPTH-entry register array for the fetch queue.
//   clk, rst  : clock, asynchronous active-high reset (clears all entries)
//   wr_en     : write wr_data into entry wr_addr at the rising edge
//   rd_addr   : asynchronous read address
//   rd_data   : entry at rd_addr, same cycle
// Entries reset to zero so the head output reads as zero straight out of reset.
module fq_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fetch_entry_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output fetch_entry_t rd_data
);

  fetch_entry_t mem_reg [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction-fetch stage: owns the fetch PC, reads the ROM,
// buffers {pc, instr} entries and hands them to decode.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : fetch_queue_if.master (ROM port, redirect, decode handshake, count)
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty and
// decode is ready, the ROM word goes straight to the output in the same cycle
// instead of spending a cycle in the queue.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]  fetch_pc_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic         empty;
  logic         full;
  logic         bypass;
  logic         q_pop;
  logic         push;
  logic         wr_en;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && !bus.redirect_valid && bus.out_ready;
`else
  assign bypass = 1'b0;
`endif

  // A redirect freezes the queue for the cycle: nothing is popped or pushed.
  assign q_pop = !empty && bus.out_ready && !bus.redirect_valid;
  // A full queue can still accept the ROM word when the head leaves this cycle.
  assign push  = !bus.redirect_valid && (!full || q_pop);
  // A bypassed word is consumed directly and never occupies a slot.
  assign wr_en = push && !bypass;

  assign wr_entry.pc    = fetch_pc_reg;
  assign wr_entry.instr = bus.imem_data;

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_reg),
    .wr_data(wr_entry),
    .rd_addr(rd_ptr_reg),
    .rd_data(head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc_reg <= bus.redirect_pc;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (push) begin
        fetch_pc_reg <= fetch_pc_reg + 1'b1;
      end
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (q_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(wr_en) - CNT_W'(q_pop);
    end
  end

  assign bus.imem_addr = fetch_pc_reg;
  assign bus.out_valid = (!empty || bypass) && !bus.redirect_valid;
  assign bus.out_instr = bypass ? bus.imem_data : head.instr;
  assign bus.out_pc    = bypass ? fetch_pc_reg  : head.pc;
  assign bus.count     = count_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed self-checking bench for fetch_queue.
// Drives a combinational 8-word ROM and walks through streaming, saturation,
// full-queue throughput, redirect and mid-stream reset.
module tb_fetch_queue;
  import cpu_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [INSTR_W-1:0] rom [0:7] = '{12'd576, 12'd1152, 12'd1728, 12'd2304,
                                    12'd505, 12'd0, 12'd0, 12'd0};

  fetch_queue_if #(.DEPTH(4)) bus ();

  assign bus.imem_data = rom[bus.imem_addr];

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) begin
      $display("vec %0d %s obs=%0d", vectors, tag, obs);
    end else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    #2;
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_count", bus.count, 0);
    chk("reset_pc", bus.out_pc, 0);
    chk("reset_instr", bus.out_instr, 0);
    chk("reset_addr", bus.imem_addr, 0);

    // Stream with decode always ready: one item per cycle, pc wraps 7 -> 0.
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("first_valid", bus.out_valid, 1);
    chk("first_instr", bus.out_instr, 576);
`else
    chk("first_valid", bus.out_valid, 0);
    chk("first_addr", bus.imem_addr, 0);
`endif
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_pc", bus.out_pc, (k + BYP) % 8);
      chk("stream_instr", bus.out_instr, rom[(k + BYP) % 8]);
      chk("stream_count", bus.count, 1 - BYP);
    end

    // Reset asserted mid-stream clears outputs immediately.
    rst = 1'b1;
    #1;
    chk("rst1_valid", bus.out_valid, 0);
    chk("rst1_count", bus.count, 0);

    // Decode stalled: occupancy saturates at 4, fetch address holds at 4.
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("sat_count", bus.count, (c < 4) ? c : 4);
      chk("sat_addr", bus.imem_addr, (c < 4) ? c : 4);
    end
    chk("sat_valid", bus.out_valid, 1);
    chk("sat_head_pc", bus.out_pc, 0);

    // Full queue drained while refilling: count stays at 4, stream continuous.
    bus.out_ready = 1'b1;
    #1;
    chk("full_head_pc", bus.out_pc, 0);
    chk("full_head_instr", bus.out_instr, 576);
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("full_count", bus.count, 4);
      chk("full_pc", bus.out_pc, j % 8);
      chk("full_instr", bus.out_instr, rom[j % 8]);
    end
    chk("full_addr", bus.imem_addr, 2);

    // Build count=3 holding pcs 0,1,2, then redirect to 2.
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 3'd0;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_redir_count", bus.count, 3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 3'd2;
    bus.out_ready      = 1'b1;
    #1;
    chk("redir_valid", bus.out_valid, 0);
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_count", bus.count, 0);
    chk("redir_addr", bus.imem_addr, 2);
`ifdef FETCH_QUEUE_BYPASS_EN
    #1;
    chk("redir_first_valid", bus.out_valid, 1);
    chk("redir_first_pc", bus.out_pc, 2);
    chk("redir_first_instr", bus.out_instr, 1728);
`else
    #1;
    chk("redir_gap_valid", bus.out_valid, 0);
    tick();
    chk("redir_first_valid", bus.out_valid, 1);
    chk("redir_first_pc", bus.out_pc, 2);
    chk("redir_first_instr", bus.out_instr, 1728);
`endif

    // Build count=2 with fetch_pc=5, then reset in the middle of a cycle.
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 3'd3;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_count", bus.count, 2);
    chk("pre_rst_addr", bus.imem_addr, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("rst2_valid", bus.out_valid, 0);
    chk("rst2_count", bus.count, 0);
    chk("rst2_addr", bus.imem_addr, 0);
    chk("rst2_pc", bus.out_pc, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    #1;
    chk("restart_pc0", bus.out_pc, 0);
    chk("restart_instr0", bus.out_instr, 576);
    tick();
    chk("restart_pc1", bus.out_pc, 1);
    chk("restart_instr1", bus.out_instr, 1152);
`else
    tick();
    chk("restart_pc0", bus.out_pc, 0);
    chk("restart_instr0", bus.out_instr, 576);
    tick();
    chk("restart_pc1", bus.out_pc, 1);
    chk("restart_instr1", bus.out_instr, 1152);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch stage sitting between the program ROM and the opcode/location decoders of the microprocessor. Owns the fetch program counter and drives the ROM address. Captures ROM output into a small FIFO of {pc, instruction} entries and presents them to decode with a valid/ready handshake. Accepts a redirect (taken jump) from the PC/branch logic that flushes queued instructions and restarts fetch at the target.

Parameters:
INSTR_W, 12, instruction width (opcode[0:2], loc1[3:5], loc2[6:8], wloc[9:11])
PC_W, 3, program address width; ROM depth 2**PC_W
DEPTH, 4, queue entries; power of two, >=2

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
imem_addr  out  PC_W  ROM read address (= fetch_pc, combinational)
imem_data  in  INSTR_W  ROM data, combinational from imem_addr in same cycle
redirect_valid  in  1  taken jump this cycle
redirect_pc  in  PC_W  jump target
out_valid  out  1  head entry available to decode
out_ready  in  1  decode consumes head this cycle
out_instr  out  INSTR_W  head instruction
out_pc  out  PC_W  address the head instruction was fetched from
count  out  clog2(DEPTH)+1  current occupancy (debug/verification)

Behaviour:
- Reset (async assert, sync release): fetch_pc=0, rd_ptr=wr_ptr=0, count=0, out_valid=0, out_instr=0, out_pc=0.
- pop = out_valid & out_ready & !redirect_valid.
- push = !redirect_valid & (count<DEPTH | pop). Push writes {fetch_pc, imem_data} at wr_ptr; fetch_pc <= fetch_pc+1 mod 2**PC_W (7 wraps to 0).
- Full with simultaneous pop: push and pop both occur; count unchanged.
- Full with no pop: no push, fetch_pc holds, imem_addr stable.
- Empty: out_valid=0; out_instr/out_pc hold their last values and carry no meaning.
- Latency (bypass off): instruction at address A is visible on out_* no earlier than one cycle after the cycle imem_addr==A.
- Redirect: takes priority over everything. Next edge: count=0, ptrs=0, fetch_pc<=redirect_pc. No push or pop that cycle; out_valid combinationally forced 0 while redirect_valid=1. Back-to-back redirects: last one wins.
- out_ready while out_valid=0: ignored.
- Reset mid-operation: queue contents discarded immediately; outputs return to reset values asynchronously.
- Entries are pointer-indexed with wrap at DEPTH. count never exceeds DEPTH or drops below 0.

Optional Feature:
Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0, !redirect_valid and out_ready=1, imem_data/fetch_pc pass straight to out_instr/out_pc with out_valid=1 in the same cycle. The entry is consumed without being written. fetch_pc still advances. Zero-cycle latency from empty.
- Undefined: no bypass; every instruction spends at least one cycle in the queue.

Decomposition:
- Shared package cpu_pkg: INSTR_W, PC_W, opcode field slice constants (OPC 0:2, LOC1 3:5, LOC2 6:8, WLOC 9:11), opcode localparams for ADD/XOR/AND/JMP/NOP, and a fetch_entry_t struct {pc, instr}.
- One sub-module is natural: fq_storage, a DEPTH-entry register array with write port and asynchronous read port. fetch_queue keeps pointers, count, fetch_pc and handshake logic.

Test Plan:
- ROM {576,1152,1728,2304,505,0,0,0}, out_ready=1 after reset release -> out stream pc 0,1,2,... with instr 576,1152,1728,2304,505. pc wraps from 7 to 0. One item per cycle.
- out_ready=0 for 10 cycles after reset -> count rises 1..4 and saturates at 4. imem_addr holds at 4. Releasing ready yields pcs 0,1,2,3 in order with no loss or duplication.
- Queue full (count=4) with out_ready=1 -> push and pop each cycle, count stays 4, stream continuous.
- redirect_valid=1, redirect_pc=2 while count=3 -> out_valid=0 that cycle, next cycle count=0 and imem_addr=2. The first delivered instr is 1728 with out_pc=2. No stale pc appears.
- rst asserted mid-stream (count=2, fetch_pc=5) -> out_valid=0 and count=0 immediately. After release, fetch restarts at pc 0.
- With FETCH_QUEUE_BYPASS_EN, empty queue, out_ready=1 -> out_valid=1 and out_instr=576 in the first cycle after reset release. Without the macro, it appears one cycle later.
